// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit: instruction-fetch front end for the multicycle RISC-V core.
// Owns the fetch PC, issues word reads to a synchronous instruction memory,
// buffers returned words in a QDEPTH-entry prefetch queue and hands them to
// decode over a valid/ready handshake. Fetch halts after the EOF sentinel
// (32'hFFFF_FFFF) is enqueued and restarts on a taken-branch redirect.
// Optional feature macro: FETCH_STATS_EN (enables the fetch_count counter;
// when undefined fetch_count is tied to zero).
module riscv_fetch_unit #(
    parameter int          IMEM_DEPTH = 1024,
    parameter int          QDEPTH     = 2,
    parameter logic [31:0] RESET_PC   = 32'h0,
    localparam int         AW         = $clog2(IMEM_DEPTH)
) (
    input  logic          CLOCK_50,
    input  logic          rst_n,
    output logic          imem_rd,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [31:0]   instr,
    output logic [31:0]   instr_pc,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          eof,
    output logic [15:0]   fetch_count
);

    localparam int          PW       = $clog2(QDEPTH);
    localparam int          CW       = PW + 2;
    localparam logic [31:0] EOF_WORD = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rd_pc_q, rd_pc_d;
    logic          inflight_q, inflight_d;
    logic          eof_q, eof_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [31:0]   qinstr_q [QDEPTH];
    logic [31:0]   qinstr_d [QDEPTH];
    logic [31:0]   qpc_q    [QDEPTH];
    logic [31:0]   qpc_d    [QDEPTH];

    logic          deq_s;
    logic          enq_s;
    logic          eof_hit_s;
    logic [CW-1:0] occ_sum_s;
    logic          room_s;

    // Handshake, response acceptance and read-credit bookkeeping.
    // A dequeue this cycle frees a slot, which keeps one-per-cycle throughput.
    always_comb begin
        deq_s     = instr_valid && instr_ready;
        enq_s     = inflight_q && (state_q == ST_RUN) && !redirect_valid;
        eof_hit_s = enq_s && (imem_rdata == EOF_WORD);
        occ_sum_s = CW'(count_q) + CW'(inflight_q) - CW'(deq_s);
        room_s    = (occ_sum_s < CW'(QDEPTH));
    end

    // FSM state register.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // FSM next state: redirect always resumes fetching; EOF enqueue halts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (redirect_valid) state_d = ST_RUN;
                else if (eof_hit_s) state_d = ST_HALT;
                else                state_d = ST_RUN;
            end
            ST_HALT: begin
                if (redirect_valid) state_d = ST_RUN;
                else                state_d = ST_HALT;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // FSM output: read strobe. Held low in reset, on redirect, and when the
    // word returning now is the EOF sentinel so nothing is fetched past it.
    always_comb begin
        imem_rd = 1'b0;
        case (state_q)
            ST_RUN:  imem_rd = rst_n && room_s && !redirect_valid && !eof_hit_s;
            ST_HALT: imem_rd = 1'b0;
            default: imem_rd = 1'b0;
        endcase
    end

    // PC, in-flight tracking and EOF flag next-state.
    always_comb begin
        if (redirect_valid)   pc_d = redirect_pc & ~32'h0000_0003;
        else if (imem_rd)     pc_d = pc_q + 32'd4;
        else                  pc_d = pc_q;
        if (imem_rd)          rd_pc_d = pc_q;
        else                  rd_pc_d = rd_pc_q;
        inflight_d = imem_rd;
        if (redirect_valid)   eof_d = 1'b0;
        else if (eof_hit_s)   eof_d = 1'b1;
        else                  eof_d = eof_q;
    end

    // Prefetch queue next-state: redirect flushes; otherwise enqueue/dequeue.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        qinstr_d = qinstr_q;
        qpc_d    = qpc_q;
        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_s) begin
                qinstr_d[wr_ptr_q] = imem_rdata;
                qpc_d[wr_ptr_q]    = rd_pc_q;
                wr_ptr_d           = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_s) rd_ptr_d = rd_ptr_q + PW'(1);
            else       rd_ptr_d = rd_ptr_q;
            count_d = count_q + (PW+1)'(enq_s) - (PW+1)'(deq_s);
        end
    end

    // Datapath and queue registers.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            rd_pc_q    <= 32'h0;
            inflight_q <= 1'b0;
            eof_q      <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            qinstr_q   <= '{default: 32'h0};
            qpc_q      <= '{default: 32'h0};
        end else begin
            pc_q       <= pc_d;
            rd_pc_q    <= rd_pc_d;
            inflight_q <= inflight_d;
            eof_q      <= eof_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            qinstr_q   <= qinstr_d;
            qpc_q      <= qpc_d;
        end
    end

    assign imem_addr   = pc_q[AW+1:2];
    assign instr_valid = (count_q != '0);
    assign instr       = qinstr_q[rd_ptr_q];
    assign instr_pc    = qpc_q[rd_ptr_q];
    assign eof         = eof_q;

`ifdef FETCH_STATS_EN
    logic [15:0] fetch_count_q, fetch_count_d;

    // Count completed handshakes, including one coinciding with a redirect.
    always_comb begin
        if (deq_s) fetch_count_d = fetch_count_q + 16'd1;
        else       fetch_count_d = fetch_count_q;
    end

    // Delivered-instruction counter register.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) fetch_count_q <= 16'h0;
        else        fetch_count_q <= fetch_count_d;
    end

    assign fetch_count = fetch_count_q;
`else
    assign fetch_count = 16'h0;
`endif

endmodule
